// File: rtl/dbg_instr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : dbg_instr_gen
//  Purpose  : Debug abstract-command instruction generator. Turns one
//             GPR/CSR/memory access command into a short RV64I/Zicsr
//             instruction sequence and injects it one instruction at a time,
//             waiting for each to retire. x31/x30 are preserved through two
//             scratch CSRs and are restored even when a step traps.
//  Ports    : clk, rst_n                  clock, async active-low reset
//             cmd_valid/cmd_ready         command handshake
//             cmd_op/cmd_regno/cmd_size   command fields
//             instr_valid/instr_ready     injected instruction handshake
//             instr                       encoded instruction (registered)
//             instr_retire/instr_exc      retirement / trap of injected instr
//             rsp_valid/rsp_err           one-cycle completion pulse + status
//             busy                        high whenever not idle
//  Revision : 1.0  initial release
// ============================================================================
module dbg_instr_gen #(
   parameter logic [11:0] DATA0_CSR = 12'h7B2,
   parameter logic [11:0] DATA1_CSR = 12'h7B3,
   parameter logic [11:0] SCR0_CSR  = 12'h7C0,
   parameter logic [11:0] SCR1_CSR  = 12'h7C1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [11:0] cmd_regno,
   input  logic [1:0]  cmd_size,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   input  logic        instr_retire,
   input  logic        instr_exc,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic        busy
);

   localparam logic [2:0] OP_GPR_RD = 3'd0;
   localparam logic [2:0] OP_GPR_WR = 3'd1;
   localparam logic [2:0] OP_CSR_RD = 3'd2;
   localparam logic [2:0] OP_CSR_WR = 3'd3;
   localparam logic [2:0] OP_MEM_RD = 3'd4;
   localparam logic [2:0] OP_MEM_WR = 3'd5;

   localparam logic [2:0] F3_RW = 3'b001;
   localparam logic [2:0] F3_RS = 3'b010;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   function automatic logic [31:0] csr_instr(input logic [11:0] csr, input logic [4:0] rs1,
                                             input logic [2:0] f3, input logic [4:0] rd);
      return {csr, rs1, f3, rd, 7'h73};
   endfunction

   // Index of the final step of each sequence (always the swap31 restore for
   // multi-step ops).
   function automatic logic [2:0] last_of(input logic [2:0] op);
      case (op)
         OP_CSR_RD, OP_CSR_WR: return 3'd3;
         OP_MEM_RD:            return 3'd4;
         OP_MEM_WR:            return 3'd6;
         default:              return 3'd0;
      endcase
   endfunction

   function automatic logic [31:0] encode(input logic [2:0] op, input logic [11:0] regno,
                                          input logic [1:0] size, input logic [2:0] step);
      logic [31:0] swap31;
      logic [31:0] swap30;
      logic [31:0] load;
      logic [31:0] store;
      swap31 = csr_instr(SCR0_CSR, 5'd31, F3_RW, 5'd31);
      swap30 = csr_instr(SCR1_CSR, 5'd30, F3_RW, 5'd30);
      load   = {12'h000, 5'd31, 1'b0, size, 5'd31, 7'h03};
      store  = {7'h00, 5'd30, 5'd31, 1'b0, size, 5'h00, 7'h23};
      case (op)
         OP_GPR_RD: return csr_instr(DATA0_CSR, regno[4:0], F3_RW, 5'd0);
         OP_GPR_WR: return csr_instr(DATA0_CSR, 5'd0, F3_RS, regno[4:0]);
         OP_CSR_RD:
            case (step)
               3'd1:    return csr_instr(regno, 5'd0, F3_RS, 5'd31);
               3'd2:    return csr_instr(DATA0_CSR, 5'd31, F3_RW, 5'd0);
               default: return swap31;
            endcase
         OP_CSR_WR:
            case (step)
               3'd1:    return csr_instr(DATA0_CSR, 5'd0, F3_RS, 5'd31);
               3'd2:    return csr_instr(regno, 5'd31, F3_RW, 5'd0);
               default: return swap31;
            endcase
         OP_MEM_RD:
            case (step)
               3'd1:    return csr_instr(DATA1_CSR, 5'd0, F3_RS, 5'd31);
               3'd2:    return load;
               3'd3:    return csr_instr(DATA0_CSR, 5'd31, F3_RW, 5'd0);
               default: return swap31;
            endcase
         OP_MEM_WR:
            case (step)
               3'd1, 3'd5: return swap30;
               3'd2:       return csr_instr(DATA1_CSR, 5'd0, F3_RS, 5'd31);
               3'd3:       return csr_instr(DATA0_CSR, 5'd0, F3_RS, 5'd30);
               3'd4:       return store;
               default:    return swap31;
            endcase
         default: return 32'h0;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [11:0] regno_q, regno_d;
   logic [1:0]  size_q, size_d;
   logic [2:0]  step_q, step_d;
   logic        saved31_q, saved31_d;
   logic        saved30_q, saved30_d;
   logic        err_q, err_d;
   logic [31:0] instr_q, instr_d;

   logic        cmd_illegal;
   logic [2:0]  last_step;
   logic [2:0]  restore_start;
   logic        have_next;
   logic [2:0]  next_step;

   assign cmd_illegal   = (cmd_op[2:1] == 2'b11) ||
                          ((cmd_op[2:1] == 2'b00) && (cmd_regno[11:5] != 7'd0));
   assign last_step     = last_of(op_q);
   // Steps from here on are restore swaps: a trap there just moves on.
   assign restore_start = (op_q == OP_MEM_WR) ? 3'd5 : last_step;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      regno_d   = regno_q;
      size_d    = size_q;
      step_d    = step_q;
      saved31_d = saved31_q;
      saved30_d = saved30_q;
      err_d     = err_q;
      instr_d   = instr_q;
      have_next = 1'b0;
      next_step = step_q + 3'd1;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d      = cmd_op;
               regno_d   = cmd_regno;
               size_d    = cmd_size;
               step_d    = 3'd0;
               saved31_d = 1'b0;
               saved30_d = 1'b0;
               err_d     = cmd_illegal;
               if (cmd_illegal) begin
                  state_d = S_RESP;
               end else begin
                  instr_d = encode(cmd_op, cmd_regno, cmd_size, 3'd0);
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (instr_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            // A trap wins over a simultaneous retire.
            if (instr_exc) begin
               err_d = 1'b1;
               if (step_q >= restore_start) begin
                  have_next = (step_q != last_step);
               end else if (saved30_q) begin
                  // saved30 implies saved31, so swap31 follows naturally.
                  have_next = 1'b1;
                  next_step = last_step - 3'd1;
               end else if (saved31_q) begin
                  have_next = 1'b1;
                  next_step = last_step;
               end
            end else if (instr_retire) begin
               if ((op_q[2:1] != 2'b00) && (step_q == 3'd0)) saved31_d = 1'b1;
               if ((op_q == OP_MEM_WR) && (step_q == 3'd1))  saved30_d = 1'b1;
               have_next = (step_q != last_step);
            end
            if (instr_exc || instr_retire) begin
               if (have_next) begin
                  step_d  = next_step;
                  instr_d = encode(op_q, regno_q, size_q, next_step);
                  state_d = S_ISSUE;
               end else begin
                  state_d = S_RESP;
               end
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= 3'd0;
         regno_q   <= 12'd0;
         size_q    <= 2'd0;
         step_q    <= 3'd0;
         saved31_q <= 1'b0;
         saved30_q <= 1'b0;
         err_q     <= 1'b0;
         instr_q   <= 32'h0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         regno_q   <= regno_d;
         size_q    <= size_d;
         step_q    <= step_d;
         saved31_q <= saved31_d;
         saved30_q <= saved30_d;
         err_q     <= err_d;
         instr_q   <= instr_d;
      end
   end

   // cmd_ready is gated by rst_n so every output reads 0 while reset is held.
   assign cmd_ready   = (state_q == S_IDLE) && rst_n;
   assign instr_valid = (state_q == S_ISSUE);
   assign instr       = instr_q;
   assign rsp_valid   = (state_q == S_RESP);
   assign rsp_err     = (state_q == S_RESP) && err_q;
   assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dbg_instr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dbg_instr_gen
//  Purpose  : Self-checking bench for dbg_instr_gen: directed scenarios plus
//             randomized commands checked against a queue-based sequence
//             model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dbg_instr_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [11:0] cmd_regno;
   logic [1:0]  cmd_size;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic        instr_retire;
   logic        instr_exc;
   logic        rsp_valid;
   logic        rsp_err;
   logic        busy;

   always #5 clk = ~clk;

   dbg_instr_gen dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_regno    (cmd_regno),
      .cmd_size     (cmd_size),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr        (instr),
      .instr_retire (instr_retire),
      .instr_exc    (instr_exc),
      .rsp_valid    (rsp_valid),
      .rsp_err      (rsp_err),
      .busy         (busy)
   );

   int n_vec;
   int n_bad;

   // Observations gathered by the driver.
   logic [31:0] obs_q[$];
   bit          obs_rsp, obs_err, obs_stable, obs_quiet, obs_rdy_bad, obs_pulse_ok, obs_timeout;
   int          obs_idle_polls;

   // Model output.
   logic [31:0] exp_q[$];
   bit          exp_err;

   function automatic logic [31:0] csr_i(input logic [11:0] csr, input int rs1, input int f3, input int rd);
      return {csr, rs1[4:0], f3[2:0], rd[4:0], 7'h73};
   endfunction

   function automatic bit seq_match();
      if (obs_q.size() != exp_q.size()) return 1'b0;
      foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) return 1'b0;
      return 1'b1;
   endfunction

   // Reference: list the nominal instructions with a role tag, walk them
   // applying the trap mask, and on a trap outside the restore tail emit the
   // restore swaps implied by which saves actually retired.
   task automatic model(input int op, input logic [11:0] r, input int sz, input logic [15:0] mask);
      logic [31:0] seq[$];
      int          kind[$];   // 0 plain, 1 save31, 2 save30, 3 restore
      logic [31:0] sw31, sw30, ldi, sti;
      bit          s31, s30, aborted, illegal;
      int          n;
      logic [1:0]  s2;
      s2   = sz[1:0];
      sw31 = csr_i(12'h7C0, 31, 1, 31);
      sw30 = csr_i(12'h7C1, 30, 1, 30);
      ldi  = {12'h000, 5'd31, 1'b0, s2, 5'd31, 7'h03};
      sti  = {7'h00, 5'd30, 5'd31, 1'b0, s2, 5'h00, 7'h23};
      illegal = 1'b0;
      seq = {}; kind = {};
      case (op)
         0: if (r[11:5] != 0) illegal = 1'b1;
            else begin seq = {csr_i(12'h7B2, int'(r[4:0]), 1, 0)}; kind = {0}; end
         1: if (r[11:5] != 0) illegal = 1'b1;
            else begin seq = {csr_i(12'h7B2, 0, 2, int'(r[4:0]))}; kind = {0}; end
         2: begin seq = {sw31, csr_i(r, 0, 2, 31), csr_i(12'h7B2, 31, 1, 0), sw31}; kind = {1, 0, 0, 3}; end
         3: begin seq = {sw31, csr_i(12'h7B2, 0, 2, 31), csr_i(r, 31, 1, 0), sw31}; kind = {1, 0, 0, 3}; end
         4: begin seq = {sw31, csr_i(12'h7B3, 0, 2, 31), ldi, csr_i(12'h7B2, 31, 1, 0), sw31};
                  kind = {1, 0, 0, 0, 3}; end
         5: begin seq = {sw31, sw30, csr_i(12'h7B3, 0, 2, 31), csr_i(12'h7B2, 0, 2, 30), sti, sw30, sw31};
                  kind = {1, 2, 0, 0, 0, 3, 3}; end
         default: illegal = 1'b1;
      endcase
      exp_q = {}; exp_err = illegal;
      s31 = 0; s30 = 0; aborted = 0; n = 0;
      for (int i = 0; i < seq.size() && !aborted; i++) begin
         exp_q.push_back(seq[i]);
         if (mask[n]) begin
            exp_err = 1'b1;
            if (kind[i] != 3) aborted = 1'b1;
         end else begin
            if (kind[i] == 1) s31 = 1'b1;
            if (kind[i] == 2) s30 = 1'b1;
         end
         n++;
      end
      if (aborted) begin
         if (s30) exp_q.push_back(sw30);
         if (s31) exp_q.push_back(sw31);
      end
   endtask

   // Drive one command to completion and record what the DUT did. Starts and
   // ends at a poll point (#1 after a rising edge). stall/dly < 0 => random.
   task automatic run_cmd(input int op, input logic [11:0] r, input int sz,
                          input logic [15:0] mask, input int stall, input int dly);
      logic [31:0] held;
      int          st, d, n, budget;
      bit          done;
      obs_q = {}; obs_rsp = 0; obs_err = 0; obs_stable = 1; obs_quiet = 1;
      obs_rdy_bad = 0; obs_pulse_ok = 0; obs_timeout = 0; obs_idle_polls = 0;
      n = 0; budget = 0; done = 0;
      if (!cmd_ready) obs_rdy_bad = 1;
      cmd_valid = 1; cmd_op = op[2:0]; cmd_regno = r; cmd_size = sz[1:0];
      @(posedge clk); #1;
      cmd_valid = 0; cmd_op = 3'($urandom); cmd_regno = 12'($urandom); cmd_size = 2'($urandom);
      while (!done && budget < 200) begin
         budget++;
         if (cmd_ready) obs_rdy_bad = 1;
         if (rsp_valid) begin
            obs_rsp = 1; obs_err = rsp_err; done = 1;
            @(posedge clk); #1;
            obs_pulse_ok = !rsp_valid && cmd_ready && !busy;
         end else if (instr_valid) begin
            held = instr;
            obs_q.push_back(instr);
            st = (stall >= 0) ? stall : $urandom_range(0, 3);
            for (int k = 0; k < st; k++) begin
               // retire/exc while not waiting must be ignored
               instr_ready = 0; instr_retire = 1'($urandom); instr_exc = 1'($urandom);
               @(posedge clk); #1;
               instr_retire = 0; instr_exc = 0;
               if (!instr_valid || instr !== held) obs_stable = 0;
            end
            instr_ready = 1;
            @(posedge clk); #1;
            instr_ready = 0;
            d = (dly >= 0) ? dly : $urandom_range(0, 3);
            for (int k = 0; k < d; k++) begin
               if (instr_valid || rsp_valid) obs_quiet = 0;
               @(posedge clk); #1;
            end
            if (mask[n]) begin instr_exc = 1; instr_retire = 1'($urandom); end
            else instr_retire = 1;
            n++;
            @(posedge clk); #1;
            instr_exc = 0; instr_retire = 0;
         end else begin
            obs_idle_polls++;
            @(posedge clk); #1;
         end
      end
      if (!done) obs_timeout = 1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({instr_valid, instr, rsp_valid, rsp_err, busy} !== 36'h0) begin
         n_bad++;
         $display("FAIL reset_outputs: got iv=%b instr=%h rv=%b re=%b busy=%b, want all 0",
                  instr_valid, instr, rsp_valid, rsp_err, busy);
      end
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      n_vec++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release: got cmd_ready=%b busy=%b, want 1/0", cmd_ready, busy);
      end
   endtask

   task automatic test_gpr_rd();
      run_cmd(0, 12'd5, 0, 16'h0, 0, 1);
      n_vec++;
      if (obs_q.size() != 1 || obs_q[0] !== 32'h7B229073) begin
         n_bad++;
         $display("FAIL gpr_rd_instr: got %0d instrs first=%h, want 1 x 7b229073", obs_q.size(), obs_q[0]);
      end
      n_vec++;
      if (!obs_rsp || obs_err || obs_idle_polls != 0 || !obs_pulse_ok || obs_rdy_bad) begin
         n_bad++;
         $display("FAIL gpr_rd_rsp: got rsp=%b err=%b idle=%0d pulse_ok=%b rdy_bad=%b, want 1 0 0 1 0",
                  obs_rsp, obs_err, obs_idle_polls, obs_pulse_ok, obs_rdy_bad);
      end
   endtask

   task automatic test_gpr_wr_stall();
      run_cmd(1, 12'd5, 0, 16'h0, 3, 0);
      n_vec++;
      if (obs_q.size() != 1 || obs_q[0] !== 32'h7B2022F3 || !obs_stable) begin
         n_bad++;
         $display("FAIL gpr_wr_stall: got %0d instrs first=%h stable=%b, want 1 x 7b2022f3 stable=1",
                  obs_q.size(), obs_q[0], obs_stable);
      end
      n_vec++;
      if (!obs_rsp || obs_err || obs_idle_polls != 0) begin
         n_bad++;
         $display("FAIL gpr_wr_rsp: got rsp=%b err=%b idle=%0d, want 1 0 0", obs_rsp, obs_err, obs_idle_polls);
      end
   endtask

   task automatic test_csr_rd();
      exp_q = {32'h7C0F9FF3, 32'h30002FF3, 32'h7B2F9073, 32'h7C0F9FF3};
      run_cmd(2, 12'h300, 0, 16'h0, -1, -1);
      n_vec++;
      if (!seq_match()) begin
         n_bad++;
         $display("FAIL csr_rd_seq: got %0d instrs [%h %h %h %h], want 7c0f9ff3 30002ff3 7b2f9073 7c0f9ff3",
                  obs_q.size(), obs_q[0], obs_q[1], obs_q[2], obs_q[3]);
      end
      n_vec++;
      if (!obs_rsp || obs_err || !obs_stable || !obs_quiet) begin
         n_bad++;
         $display("FAIL csr_rd_rsp: got rsp=%b err=%b stable=%b quiet=%b, want 1 0 1 1",
                  obs_rsp, obs_err, obs_stable, obs_quiet);
      end
   endtask

   task automatic test_mem_rd_exc();
      exp_q = {32'h7C0F9FF3, 32'h7B302FF3, 32'h000FBF83, 32'h7C0F9FF3};
      run_cmd(4, 12'h000, 3, 16'h0004, -1, -1);
      n_vec++;
      if (!seq_match()) begin
         n_bad++;
         $display("FAIL mem_rd_exc_seq: got %0d instrs [%h %h %h %h], want 7c0f9ff3 7b302ff3 000fbf83 7c0f9ff3",
                  obs_q.size(), obs_q[0], obs_q[1], obs_q[2], obs_q[3]);
      end
      n_vec++;
      if (!obs_rsp || !obs_err || obs_idle_polls != 0) begin
         n_bad++;
         $display("FAIL mem_rd_exc_rsp: got rsp=%b err=%b idle=%0d, want 1 1 0", obs_rsp, obs_err, obs_idle_polls);
      end
   endtask

   task automatic test_illegal();
      run_cmd(7, 12'h001, 0, 16'h0, 0, 0);
      n_vec++;
      if (obs_q.size() != 0 || !obs_rsp || !obs_err || obs_idle_polls != 0) begin
         n_bad++;
         $display("FAIL illegal_op: got instrs=%0d rsp=%b err=%b idle=%0d, want 0 1 1 0",
                  obs_q.size(), obs_rsp, obs_err, obs_idle_polls);
      end
      run_cmd(0, 12'h020, 0, 16'h0, 0, 0);
      n_vec++;
      if (obs_q.size() != 0 || !obs_rsp || !obs_err || obs_idle_polls != 0) begin
         n_bad++;
         $display("FAIL illegal_gpr: got instrs=%0d rsp=%b err=%b idle=%0d, want 0 1 1 0",
                  obs_q.size(), obs_rsp, obs_err, obs_idle_polls);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] want3;
      bit          noise;
      want3 = csr_i(12'h7B2, 0, 2, 30);
      cmd_valid = 1; cmd_op = 3'd5; cmd_regno = 12'h0; cmd_size = 2'd2;
      @(posedge clk); #1;
      cmd_valid = 0;
      for (int i = 0; i < 3; i++) begin
         instr_ready = 1; @(posedge clk); #1; instr_ready = 0;
         instr_retire = 1; @(posedge clk); #1; instr_retire = 0;
      end
      n_vec++;
      if (instr_valid !== 1'b1 || instr !== want3) begin
         n_bad++;
         $display("FAIL rst_mid_step3: got iv=%b instr=%h, want 1 %h", instr_valid, instr, want3);
      end
      instr_ready = 1; @(posedge clk); #1; instr_ready = 0;
      n_vec++;
      if (busy !== 1'b1 || instr_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_wait: got busy=%b iv=%b, want 1 0", busy, instr_valid);
      end
      #2 rst_n = 0;
      #1;
      n_vec++;
      if ({instr_valid, instr, rsp_valid, rsp_err, busy, cmd_ready} !== 37'h0) begin
         n_bad++;
         $display("FAIL rst_mid_async: got iv=%b instr=%h rv=%b re=%b busy=%b rdy=%b, want all 0",
                  instr_valid, instr, rsp_valid, rsp_err, busy, cmd_ready);
      end
      @(negedge clk); rst_n = 1;
      noise = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (!cmd_ready || instr_valid || rsp_valid || busy) noise = 1;
      end
      n_vec++;
      if (noise) begin
         n_bad++;
         $display("FAIL rst_mid_after: got activity after release (rdy=%b iv=%b rv=%b), want idle",
                  cmd_ready, instr_valid, rsp_valid);
      end
      run_cmd(0, 12'd7, 0, 16'h0, -1, -1);
      n_vec++;
      if (obs_q.size() != 1 || obs_q[0] !== 32'h7B239073 || !obs_rsp || obs_err) begin
         n_bad++;
         $display("FAIL rst_mid_followup: got %0d instrs first=%h rsp=%b err=%b, want 1 x 7b239073 1 0",
                  obs_q.size(), obs_q[0], obs_rsp, obs_err);
      end
   endtask

   task automatic test_back_to_back();
      int          op;
      logic [11:0] r;
      for (int i = 0; i < 6; i++) begin
         op = i % 4;
         r  = (op < 2) ? 12'($urandom_range(0, 31)) : 12'($urandom);
         model(op, r, 0, 16'h0);
         run_cmd(op, r, 0, 16'h0, 0, 0);
         n_vec++;
         if (!seq_match() || obs_err != exp_err || !obs_rsp || obs_idle_polls != 0 || !obs_pulse_ok) begin
            n_bad++;
            $display("FAIL back_to_back[%0d]: op=%0d got %0d instrs err=%b idle=%0d pulse=%b, want %0d instrs err=%b idle=0",
                     i, op, obs_q.size(), obs_err, obs_idle_polls, obs_pulse_ok, exp_q.size(), exp_err);
         end
      end
   endtask

   task automatic test_random();
      int          op, sz;
      logic [11:0] r;
      logic [15:0] mask;
      for (int i = 0; i < 60; i++) begin
         op = $urandom_range(0, 7);
         sz = $urandom_range(0, 3);
         r  = 12'($urandom);
         if (op < 2) begin
            r[11:5] = 7'd0;
            if ($urandom_range(0, 7) == 0) r[11:5] = 7'($urandom_range(1, 127));
         end
         mask = 16'h0;
         for (int b = 0; b < 16; b++) if ($urandom_range(0, 5) == 0) mask[b] = 1'b1;
         model(op, r, sz, mask);
         run_cmd(op, r, sz, mask, -1, -1);
         n_vec++;
         if (!seq_match()) begin
            n_bad++;
            $display("FAIL rand_seq[%0d]: op=%0d r=%h sz=%0d mask=%h got %0d instrs (last %h), want %0d (last %h)",
                     i, op, r, sz, mask, obs_q.size(), obs_q[$], exp_q.size(), exp_q[$]);
         end
         n_vec++;
         if (!obs_rsp || obs_timeout || obs_err != exp_err) begin
            n_bad++;
            $display("FAIL rand_rsp[%0d]: op=%0d mask=%h got rsp=%b timeout=%b err=%b, want 1 0 %b",
                     i, op, mask, obs_rsp, obs_timeout, obs_err, exp_err);
         end
         n_vec++;
         if (!obs_stable || !obs_quiet || obs_rdy_bad || !obs_pulse_ok || obs_idle_polls != 0) begin
            n_bad++;
            $display("FAIL rand_proto[%0d]: got stable=%b quiet=%b rdy_bad=%b pulse=%b idle=%0d, want 1 1 0 1 0",
                     i, obs_stable, obs_quiet, obs_rdy_bad, obs_pulse_ok, obs_idle_polls);
         end
      end
   endtask

   initial begin
      n_vec = 0; n_bad = 0;
      rst_n = 0; cmd_valid = 0; cmd_op = 0; cmd_regno = 0; cmd_size = 0;
      instr_ready = 0; instr_retire = 0; instr_exc = 0;
      test_reset();
      test_gpr_rd();
      test_gpr_wr_stall();
      test_csr_rd();
      test_mem_rd_exc();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", n_vec, n_bad);
      $fatal(1);
   end

endmodule
`default_nettype wire
